// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS active digits through one shared BCD-to-7-segment decoder, with shadow/active banks.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (position > 0) while scanning.
module display_scan_controller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter logic [3:0] BLANK_CODE = 4'b1111,
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                  clock_50,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [IDX_W-1:0]      ld_index,
  input  logic [3:0]            ld_data,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  digit_err,
  output logic                  frame_done
);
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [PRE_W-1:0] presc, presc_nxt;
  logic [3:0]       shadow [NUM_DIGITS];
  logic [3:0]       active [NUM_DIGITS];
  logic             dirty;
  logic             ld_fire;
  logic             idx_ok;
  logic             slot_end;
  logic             last_slot;
  logic [3:0]       cur_code;
  logic             blank_lz;

  assign ld_fire   = ld_valid && ld_ready;
  assign idx_ok    = (32'(ld_index) < NUM_DIGITS);
  assign slot_end  = (presc == PRE_W'(SCAN_DIV - 1));
  assign last_slot = (ptr == IDX_W'(NUM_DIGITS - 1));

  // State register
  always_ff @(posedge clock_50 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      presc <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      presc <= presc_nxt;
    end
  end

  // Next-state, pointer and prescaler
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    presc_nxt = presc;
    case (state)
      IDLE: begin
        ptr_nxt   = '0;
        presc_nxt = '0;
        if (en) state_nxt = SCAN;
      end
      SCAN: begin
        if (!en) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          presc_nxt = '0;
        end else if (slot_end) begin
          presc_nxt = '0;
          if (last_slot) begin
            state_nxt = COMMIT;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr + IDX_W'(1);
          end
        end else begin
          presc_nxt = presc + PRE_W'(1);
        end
      end
      COMMIT: begin
        ptr_nxt   = '0;
        presc_nxt = '0;
        state_nxt = en ? SCAN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
        presc_nxt = '0;
      end
    endcase
  end

  // Digit banks: IDLE loads go straight to active, SCAN loads wait in shadow until COMMIT
  always_ff @(posedge clock_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      dirty <= 1'b0;
    end else begin
      if (ld_fire && idx_ok) begin
        shadow[ld_index] <= ld_data;
        if (state == IDLE) active[ld_index] <= ld_data;
        else dirty <= 1'b1;
      end
      if (state == COMMIT && dirty) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) active[i] <= shadow[i];
        dirty <= 1'b0;
      end
    end
  end

  // Moore output decode from registered state
  always_comb begin
    digit_sel  = '0;
    digit_code = BLANK_CODE;
    digit_err  = 1'b0;
    frame_done = 1'b0;
    ld_ready   = 1'b1;
    cur_code   = active[ptr];
    blank_lz   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_lz = (ptr != '0);
    for (int p = 0; p < int'(NUM_DIGITS); p++) begin
      if (IDX_W'(p) >= ptr && active[p] != 4'd0) blank_lz = 1'b0;
    end
`endif
    case (state)
      SCAN: begin
        digit_sel = NUM_DIGITS'(1) << ptr;
        if (!blank_lz) begin
          digit_code = cur_code;
          digit_err  = (cur_code > 4'd9);
        end
      end
      COMMIT: begin
        frame_done = 1'b1;
        ld_ready   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed, table-driven bench for display_scan_controller with NUM_DIGITS=4, SCAN_DIV=4.
module tb_display_scan_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [1:0] ld_index = '0;
  logic [3:0] ld_data = '0;
  logic [3:0] digit_code;
  logic [3:0] digit_sel;
  logic       digit_err;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CODE(4'hF)) dut (
    .clock_50(clk), .rst(rst), .en(en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_index(ld_index), .ld_data(ld_data), .digit_code(digit_code),
    .digit_sel(digit_sel), .digit_err(digit_err), .frame_done(frame_done)
  );

  typedef struct {
    logic        en;
    logic        vld;
    logic [1:0]  idx;
    logic [3:0]  data;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected {sel, code, err, frame_done, ready}
  function automatic logic [10:0] e_idle();
    return {4'b0000, 4'hF, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic logic [10:0] e_commit();
    return {4'b0000, 4'hF, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [10:0] e_scan(input int slot, input logic [3:0] code);
    logic [3:0] sel;
    sel = 4'b0001 << slot;
    return {sel, code, (code > 4'd9), 1'b0, 1'b1};
  endfunction

  function automatic logic [3:0] slot_code(input logic [15:0] codes, input int slot);
    return codes[4*slot +: 4];
  endfunction

  function automatic logic [10:0] obs();
    return {digit_sel, digit_code, digit_err, frame_done, ld_ready};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: sel/code/err/fd/rdy got %b_%h_%b_%b_%b required %b_%h_%b_%b_%b",
               name, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string name, input logic [10:0] exp);
    tick();
    check(name, obs(), exp);
  endtask

  // From the cycle before start_k, run to and including the COMMIT cycle (k=16)
  task automatic frame_rest(input string tag, input int start_k, input logic [15:0] codes);
    for (int k = start_k; k <= 16; k++) begin
      if (k < 16) step_chk($sformatf("%s_k%0d", tag, k), e_scan(k / 4, slot_code(codes, k / 4)));
      else        step_chk($sformatf("%s_commit", tag), e_commit());
    end
  endtask

  function automatic void add(input logic e, input logic v, input logic [1:0] i,
                              input logic [3:0] d, input logic [10:0] x);
    vec_t r;
    r.en = e; r.vld = v; r.idx = i; r.data = d; r.exp = x;
    tbl.push_back(r);
  endfunction

  localparam logic [15:0] F1 = 16'h4321;
  localparam logic [15:0] F2 = 16'h4721;
  localparam logic [15:0] F4 = 16'h67A1;

  initial begin
    // IDLE loads, then one frame with a mid-frame shadow write, then the committed frame
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 2'(i), 4'(i + 1), e_idle());
    add(1'b1, 1'b0, 2'd0, 4'd0, e_scan(0, 4'd1));
    add(1'b1, 1'b1, 2'd2, 4'd7, e_scan(0, 4'd1));
    for (int k = 2; k < 16; k++) add(1'b1, 1'b0, 2'd0, 4'd0, e_scan(k / 4, slot_code(F1, k / 4)));
    add(1'b1, 1'b0, 2'd0, 4'd0, e_commit());
    for (int k = 0; k < 16; k++) add(1'b1, 1'b0, 2'd0, 4'd0, e_scan(k / 4, slot_code(F2, k / 4)));
    add(1'b1, 1'b0, 2'd0, 4'd0, e_commit());

    #1 rst = 1'b1;
    #1 check("reset", obs(), e_idle());
    tick();
    rst = 1'b0;

    foreach (tbl[i]) begin
      en = tbl[i].en; ld_valid = tbl[i].vld; ld_index = tbl[i].idx; ld_data = tbl[i].data;
      tick();
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Load request raised during COMMIT must wait for the next cycle
    ld_valid = 1'b1; ld_index = 2'd1; ld_data = 4'hA; en = 1'b1;
    step_chk("stall_k0", e_scan(0, 4'd1));
    step_chk("stall_k1", e_scan(0, 4'd1));
    ld_index = 2'd3; ld_data = 4'd5;
    step_chk("dup1_k2", e_scan(0, 4'd1));
    ld_data = 4'd6;
    step_chk("dup2_k3", e_scan(0, 4'd1));
    ld_valid = 1'b0;
    frame_rest("f3", 4, F2);

    // Frame with 0xA in slot 1; drop enable at slot 2, prescaler 1
    for (int k = 0; k <= 9; k++) step_chk($sformatf("f4_k%0d", k), e_scan(k / 4, slot_code(F4, k / 4)));
    en = 1'b0;
    step_chk("endrop_idle", e_idle());
    step_chk("endrop_idle2", e_idle());
    en = 1'b1;
    step_chk("restart_k0", e_scan(0, 4'd1));
    frame_rest("f4b", 1, F4);

    // Asynchronous reset while slot 2 is shown clears outputs and banks
    for (int k = 0; k <= 8; k++) step_chk($sformatf("f5_k%0d", k), e_scan(k / 4, slot_code(F4, k / 4)));
    #2 rst = 1'b1;
    #1 check("async_rst", obs(), e_idle());
    tick();
    rst = 1'b0;
    step_chk("post_rst_k0", e_scan(0, 4'd0));
    for (int k = 1; k <= 4; k++) step_chk($sformatf("post_rst_k%0d", k), e_scan(k / 4, 4'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
